opmode_ctrl: RTL and testbench
==============================

Name: opmode_ctrl

Overview:
Control-side companion to the DSP datapath muxes. It captures OPMODE and carry-in, then decodes them into the select and control lines that the datapath muxes consume: X/Z select, pre-/post-adder add/sub, B source and carry-in. It also flags configuration changes and holds a ready indication low until the datapath pipeline has flushed.

Parameters:
OPMODEREG, 1, 1 = OPMODE registered with CEOPMODE; 0 = opmode_q follows OPMODE combinationally.
CARRYINREG, 1, 1 = carry-in registered with CECARRYIN; 0 = combinational.
CARRYINSEL, "OPMODE5", carry source: "OPMODE5" uses opmode_q[5], "CARRYIN" uses the CARRYIN port.
B_INPUT, "DIRECT", "DIRECT" gives b_src_sel = 0; "CASCADE" gives b_src_sel = 1.
PIPE_DEPTH, 4, number of datapath cycles needed to flush after a config change (0..15).

Ports:
CLK  in  1  clock, all state on rising edge.
RST  in  1  asynchronous active-high reset.
CEOPMODE  in  1  OPMODE register enable.
CECARRYIN  in  1  carry register enable.
OPMODE  in  8  raw opmode.
CARRYIN  in  1  external carry-in.
opmode_q  out  8  effective opmode.
x_sel  out  2  = opmode_q[1:0].
z_sel  out  2  = opmode_q[3:2].
preadd_en  out  1  = opmode_q[4].
preadd_sub  out  1  = opmode_q[6].
postadd_sub  out  1  = opmode_q[7].
b_src_sel  out  1  B source select (constant from B_INPUT).
cin_out  out  1  effective carry-in to the post-adder.
cfg_change  out  1  one-cycle pulse on an opmode_q change.
ready  out  1  datapath settled.

Behaviour:
- Reset (async, RST = 1), applies immediately with no CLK edge:
  - opmode_q register = 0; carry register = 0; prev_q = 0; cfg_change = 0.
  - Settle counter = PIPE_DEPTH, so ready = 0 (ready = 1 if PIPE_DEPTH = 0).
  - RST held high freezes this state. First edge after RST falls is normal operation.
- OPMODEREG = 1: opmode_q loads OPMODE at an edge when CEOPMODE = 1, else holds. Latency is 1 cycle.
- OPMODEREG = 0: opmode_q = OPMODE; CEOPMODE is ignored.
- Decoded outputs (x_sel, z_sel, preadd_en, preadd_sub, postadd_sub) are purely combinational from opmode_q.
- Carry source: opmode_q[5] or CARRYIN, per CARRYINSEL.
  - CARRYINREG = 1: cin_out is the source registered with CECARRYIN.
  - CARRYINREG = 0: cin_out = source.
- Any other CARRYINSEL or B_INPUT value is illegal and raises an elaboration-time error.
- Change detect:
  - prev_q <= opmode_q on every edge, independent of CE.
  - cfg_change <= (opmode_q != prev_q), registered.
  - Timing: opmode_q changes at edge n, cfg_change is high from edge n+1 to edge n+2. An unchanged reload of the same value gives no pulse.
- Settle counter, width 4:
  - At an edge where (opmode_q != prev_q): load PIPE_DEPTH.
  - Else if counter != 0: decrement.
  - Else hold 0.
  - ready = (counter == 0), combinational.
  - Example, PIPE_DEPTH = 4, change at edge n: counter loads 4 at n+1, then 3, 2, 1, and reaches 0 at n+5, so ready = 1 after edge n+5.
- A change during countdown reloads PIPE_DEPTH; no underflow.
- PIPE_DEPTH = 0: ready is constant 1; cfg_change still pulses.
- Carry-only changes do not affect cfg_change or ready.
- Reset mid-countdown: the counter returns to PIPE_DEPTH, and after release it counts down normally. The reset value of opmode_q equals prev_q, so there is no spurious pulse.

Test Plan:
1. Reset, defaults: assert RST async mid-cycle -> all outputs 0 and ready = 0 immediately. Release -> ready = 1 exactly 4 edges later.
2. Decode: OPMODE = 8'b1101_0110, CEOPMODE = 1, one edge -> x_sel = 2'b10, z_sel = 2'b01, preadd_en = 1, preadd_sub = 1, postadd_sub = 1. CEOPMODE = 0 with OPMODE = 8'h00 -> outputs hold.
3. Carry, CARRYINSEL = "OPMODE5", CARRYINREG = 1: load OPMODE[5] = 1 with CECARRYIN = 1 -> cin_out = 1 one edge after opmode_q[5] = 1. Then CECARRYIN = 0 with opmode_q[5] = 0 -> cin_out stays 1. With CARRYINSEL = "CARRYIN", toggling CARRYIN -> cin_out follows 1 edge later.
4. Change/settle: after settling, load 8'h0C -> cfg_change high for exactly 1 cycle at n+1, ready low for n+1..n+4, high at n+5. Reload 8'h0C -> no pulse, ready stays 1.
5. Retrigger: load 8'h01, then 8'h02 two edges later -> two cfg_change pulses; ready stays low until 4 edges after the second change is detected.
6. OPMODEREG = 0, PIPE_DEPTH = 0, B_INPUT = "CASCADE": OPMODE changes mid-cycle -> opmode_q follows combinationally, b_src_sel = 1, ready constantly 1, cfg_change pulses on the next edge.

Source files
------------

// File: rtl/opmode_ctrl_if.sv
// Bundle of OPMODE/carry control inputs and the decoded select lines fed to the DSP datapath muxes.
// The slave side belongs to opmode_ctrl; the master side drives the raw controls.
interface opmode_ctrl_if;
   logic       CEOPMODE;
   logic       CECARRYIN;
   logic [7:0] OPMODE;
   logic       CARRYIN;
   logic [7:0] opmode_q;
   logic [1:0] x_sel;
   logic [1:0] z_sel;
   logic       preadd_en;
   logic       preadd_sub;
   logic       postadd_sub;
   logic       b_src_sel;
   logic       cin_out;
   logic       cfg_change;
   logic       ready;

   modport slave (
      input  CEOPMODE, CECARRYIN, OPMODE, CARRYIN,
      output opmode_q, x_sel, z_sel, preadd_en, preadd_sub, postadd_sub,
             b_src_sel, cin_out, cfg_change, ready
   );

   modport master (
      output CEOPMODE, CECARRYIN, OPMODE, CARRYIN,
      input  opmode_q, x_sel, z_sel, preadd_en, preadd_sub, postadd_sub,
             b_src_sel, cin_out, cfg_change, ready
   );
endinterface

// File: rtl/opmode_ctrl.sv
// Captures OPMODE/carry-in, decodes the datapath mux selects, pulses on config changes and
// holds ready low until the datapath pipeline has flushed.
module opmode_ctrl #(
   parameter int    OPMODEREG  = 1,
   parameter int    CARRYINREG = 1,
   parameter string CARRYINSEL = "OPMODE5",
   parameter string B_INPUT    = "DIRECT",
   parameter int    PIPE_DEPTH = 4
) (
   input logic           CLK,
   input logic           RST,
   opmode_ctrl_if.slave  bus
);

   localparam logic [3:0] DEPTH = 4'(PIPE_DEPTH);

   if (!(CARRYINSEL == "OPMODE5" || CARRYINSEL == "CARRYIN")) begin : g_bad_carryinsel
      $error("opmode_ctrl: CARRYINSEL must be OPMODE5 or CARRYIN");
   end
   if (!(B_INPUT == "DIRECT" || B_INPUT == "CASCADE")) begin : g_bad_b_input
      $error("opmode_ctrl: B_INPUT must be DIRECT or CASCADE");
   end
   if (PIPE_DEPTH < 0 || PIPE_DEPTH > 15) begin : g_bad_depth
      $error("opmode_ctrl: PIPE_DEPTH must be 0..15");
   end

   logic [7:0] opm_eff;
   logic       cin_src;
   logic [7:0] prev_q;
   logic       cfg_q;
   logic [3:0] cnt_q, cnt_d;
   logic       chg;

   if (OPMODEREG != 0) begin : g_opm_reg
      logic [7:0] opm_q;
      always_ff @(posedge CLK or posedge RST) begin
         if (RST)               opm_q <= '0;
         else if (bus.CEOPMODE) opm_q <= bus.OPMODE;
      end
      assign opm_eff = opm_q;
   end else begin : g_opm_comb
      assign opm_eff = bus.OPMODE;
   end

   if (CARRYINSEL == "CARRYIN") begin : g_cin_port
      assign cin_src = bus.CARRYIN;
   end else begin : g_cin_opm
      assign cin_src = opm_eff[5];
   end

   if (CARRYINREG != 0) begin : g_cin_reg
      logic cin_q;
      always_ff @(posedge CLK or posedge RST) begin
         if (RST)                cin_q <= 1'b0;
         else if (bus.CECARRYIN) cin_q <= cin_src;
      end
      assign bus.cin_out = cin_q;
   end else begin : g_cin_comb
      assign bus.cin_out = cin_src;
   end

   // Carry is deliberately excluded: only opmode changes disturb the datapath pipeline.
   assign chg = (opm_eff != prev_q);

   always_comb begin
      cnt_d = cnt_q;
      if (chg)               cnt_d = DEPTH;
      else if (cnt_q != '0)  cnt_d = cnt_q - 4'd1;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prev_q <= '0;
         cfg_q  <= 1'b0;
         cnt_q  <= DEPTH;
      end else begin
         prev_q <= opm_eff;
         cfg_q  <= chg;
         cnt_q  <= cnt_d;
      end
   end

   assign bus.opmode_q    = opm_eff;
   assign bus.x_sel       = opm_eff[1:0];
   assign bus.z_sel       = opm_eff[3:2];
   assign bus.preadd_en   = opm_eff[4];
   assign bus.preadd_sub  = opm_eff[6];
   assign bus.postadd_sub = opm_eff[7];
   assign bus.b_src_sel   = (B_INPUT == "CASCADE");
   assign bus.cfg_change  = cfg_q;
   assign bus.ready       = (cnt_q == 4'd0);

endmodule

// File: tb/tb_opmode_ctrl.sv
// Directed bench for opmode_ctrl: default, CARRYIN-sourced and combinational/cascade variants
// share one stimulus set; expected values are hand-computed constants.
module tb_opmode_ctrl;
   logic       CLK;
   logic       RST;
   logic       ce_opm;
   logic       ce_cin;
   logic [7:0] opmode;
   logic       carryin;

   int n_chk;
   int n_err;

   opmode_ctrl_if if_da ();
   opmode_ctrl_if if_dc ();
   opmode_ctrl_if if_dm ();

   assign if_da.CEOPMODE  = ce_opm;
   assign if_da.CECARRYIN = ce_cin;
   assign if_da.OPMODE    = opmode;
   assign if_da.CARRYIN   = carryin;
   assign if_dc.CEOPMODE  = ce_opm;
   assign if_dc.CECARRYIN = ce_cin;
   assign if_dc.OPMODE    = opmode;
   assign if_dc.CARRYIN   = carryin;
   assign if_dm.CEOPMODE  = ce_opm;
   assign if_dm.CECARRYIN = ce_cin;
   assign if_dm.OPMODE    = opmode;
   assign if_dm.CARRYIN   = carryin;

   opmode_ctrl u_da (.CLK(CLK), .RST(RST), .bus(if_da));

   opmode_ctrl #(.CARRYINSEL("CARRYIN")) u_dc (.CLK(CLK), .RST(RST), .bus(if_dc));

   opmode_ctrl #(.OPMODEREG(0), .CARRYINREG(0), .B_INPUT("CASCADE"), .PIPE_DEPTH(0))
      u_dm (.CLK(CLK), .RST(RST), .bus(if_dm));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk   = 0;
      n_err   = 0;
      RST     = 1'b0;
      ce_opm  = 1'b0;
      ce_cin  = 1'b0;
      opmode  = 8'h00;
      carryin = 1'b0;

      // async reset between edges
      #2 RST = 1'b1;
      #1;
      chk("rst_opm",   32'(if_da.opmode_q), 32'h00);
      chk("rst_cfg",   32'(if_da.cfg_change), 32'h0);
      chk("rst_ready", 32'(if_da.ready), 32'h0);
      chk("rst_cin",   32'(if_da.cin_out), 32'h0);
      chk("rst_bsrc",  32'(if_da.b_src_sel), 32'h0);
      chk("rst_dm_ready", 32'(if_dm.ready), 32'h1);
      tick();
      tick();
      chk("rst_hold_ready", 32'(if_da.ready), 32'h0);
      RST = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("rel_ready%0d", i), 32'(if_da.ready), 32'(i == 4));
         chk($sformatf("rel_cfg%0d", i), 32'(if_da.cfg_change), 32'h0);
      end

      // decode
      opmode = 8'hD6;
      ce_opm = 1'b1;
      tick();
      chk("dec_opm",  32'(if_da.opmode_q), 32'hD6);
      chk("dec_x",    32'(if_da.x_sel), 32'h2);
      chk("dec_z",    32'(if_da.z_sel), 32'h1);
      chk("dec_pre",  32'(if_da.preadd_en), 32'h1);
      chk("dec_psub", 32'(if_da.preadd_sub), 32'h1);
      chk("dec_qsub", 32'(if_da.postadd_sub), 32'h1);
      chk("dec_cfg0", 32'(if_da.cfg_change), 32'h0);
      ce_opm = 1'b0;
      opmode = 8'h00;
      tick();
      chk("hold_opm", 32'(if_da.opmode_q), 32'hD6);
      chk("hold_x",   32'(if_da.x_sel), 32'h2);
      chk("hold_cfg", 32'(if_da.cfg_change), 32'h1);
      chk("hold_rdy", 32'(if_da.ready), 32'h0);
      for (int i = 0; i < 4; i++) tick();
      chk("dec_settled", 32'(if_da.ready), 32'h1);

      // carry from opmode[5], registered
      opmode = 8'h20;
      ce_opm = 1'b1;
      ce_cin = 1'b1;
      tick();
      chk("cin_lat0", 32'(if_da.cin_out), 32'h0);
      tick();
      chk("cin_lat1", 32'(if_da.cin_out), 32'h1);
      ce_cin = 1'b0;
      opmode = 8'h00;
      tick();
      tick();
      chk("cin_hold_opm", 32'(if_da.opmode_q), 32'h00);
      chk("cin_hold",     32'(if_da.cin_out), 32'h1);
      ce_cin = 1'b1;
      tick();
      chk("cin_reload", 32'(if_da.cin_out), 32'h0);

      // carry from the CARRYIN port
      carryin = 1'b1;
      chk("cport_pre", 32'(if_dc.cin_out), 32'h0);
      tick();
      chk("cport_1",   32'(if_dc.cin_out), 32'h1);
      chk("cport_da",  32'(if_da.cin_out), 32'h0);
      carryin = 1'b0;
      tick();
      chk("cport_0",   32'(if_dc.cin_out), 32'h0);
      ce_cin  = 1'b0;
      carryin = 1'b1;
      tick();
      chk("cport_hold", 32'(if_dc.cin_out), 32'h0);
      carryin = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("pre_chg_ready", 32'(if_da.ready), 32'h1);

      // change and settle
      opmode = 8'h0C;
      ce_opm = 1'b1;
      tick();
      chk("chg_n_cfg",   32'(if_da.cfg_change), 32'h0);
      chk("chg_n_ready", 32'(if_da.ready), 32'h1);
      ce_opm = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("chg_cfg%0d", k), 32'(if_da.cfg_change), 32'(k == 1));
         chk($sformatf("chg_rdy%0d", k), 32'(if_da.ready), 32'(k >= 5));
      end
      ce_opm = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         tick();
         chk($sformatf("same_cfg%0d", k), 32'(if_da.cfg_change), 32'h0);
         chk($sformatf("same_rdy%0d", k), 32'(if_da.ready), 32'h1);
      end

      // retrigger during countdown
      opmode = 8'h01;
      tick();
      tick();
      chk("rt_cfg_a", 32'(if_da.cfg_change), 32'h1);
      opmode = 8'h02;
      tick();
      chk("rt_gap_cfg", 32'(if_da.cfg_change), 32'h0);
      chk("rt_gap_rdy", 32'(if_da.ready), 32'h0);
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk($sformatf("rt_cfg%0d", k), 32'(if_da.cfg_change), 32'(k == 1));
         chk($sformatf("rt_rdy%0d", k), 32'(if_da.ready), 32'(k >= 5));
      end

      // reset mid-countdown
      opmode = 8'h03;
      tick();
      tick();
      tick();
      opmode = 8'h00;
      #2 RST = 1'b1;
      #1;
      chk("mrst_opm",   32'(if_da.opmode_q), 32'h00);
      chk("mrst_ready", 32'(if_da.ready), 32'h0);
      chk("mrst_cfg",   32'(if_da.cfg_change), 32'h0);
      tick();
      RST = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("mrst_rdy%0d", k), 32'(if_da.ready), 32'(k == 4));
         chk($sformatf("mrst_cfg%0d", k), 32'(if_da.cfg_change), 32'h0);
      end

      // combinational opmode, zero depth, cascade B
      ce_opm = 1'b0;
      chk("dm_bsrc", 32'(if_dm.b_src_sel), 32'h1);
      #3 opmode = 8'hA5;
      #1;
      chk("dm_opm",   32'(if_dm.opmode_q), 32'hA5);
      chk("dm_x",     32'(if_dm.x_sel), 32'h1);
      chk("dm_cin",   32'(if_dm.cin_out), 32'h1);
      chk("dm_cfg0",  32'(if_dm.cfg_change), 32'h0);
      chk("dm_rdy0",  32'(if_dm.ready), 32'h1);
      chk("da_noce",  32'(if_da.opmode_q), 32'h00);
      tick();
      chk("dm_cfg1",  32'(if_dm.cfg_change), 32'h1);
      chk("dm_rdy1",  32'(if_dm.ready), 32'h1);
      tick();
      chk("dm_cfg2",  32'(if_dm.cfg_change), 32'h0);
      chk("dm_rdy2",  32'(if_dm.ready), 32'h1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
